// File: rtl/ysyx_22050368_regfile_sb_pkg.sv
// Shared defaults and the read-port bundle type for the NPC integer register file.
// Optional write-to-read bypass is enabled with REGFILE_BYPASS_EN.
package ysyx_22050368_regfile_sb_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned RFREG_NUM   = 32;
    localparam int unsigned RFIDX_WIDTH = $clog2(RFREG_NUM);

    typedef struct packed {
        logic [RFIDX_WIDTH-1:0] idx;
        logic [XLEN-1:0]        dat;
        logic                   busy;
    } rf_rd_port_t;

endpackage

// File: rtl/ysyx_22050368_rf_scoreboard.sv
// Per-register busy scoreboard: issue claims a destination, write-back releases it.
// A claim and a release of the same index in one cycle leave the register busy.
module ysyx_22050368_rf_scoreboard
    import ysyx_22050368_regfile_sb_pkg::*;
#(
    parameter int unsigned NREG = RFREG_NUM,
    parameter int unsigned IDXW = $clog2(NREG),
    parameter int unsigned NWR  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid_i,
    input  logic [IDXW-1:0]   iss_rd_i,
    output logic              iss_ready_o,
    input  logic [NWR-1:0]    wb_wen_i,
    input  logic [NWR*IDXW-1:0] wb_idx_i,
    output logic [NREG-1:0]   busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] clr;

    always_comb begin
        clr = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wb_wen_i[j]) begin
                clr[wb_idx_i[j*IDXW +: IDXW]] = 1'b1;
            end
        end
        clr[0] = 1'b0;
    end

    assign iss_ready_o = (iss_rd_i == '0) | ~busy_q[iss_rd_i] | clr[iss_rd_i];

    always_comb begin
        busy_d = busy_q & ~clr;
        if (iss_valid_i && iss_ready_o && (iss_rd_i != '0)) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/ysyx_22050368_regfile_sb.sv
// NPC integer register file: NRD combinational read ports, NWR prioritised write-back
// ports, busy scoreboard and x1 tap. Define REGFILE_BYPASS_EN for write-to-read bypass.
module ysyx_22050368_regfile_sb
    import ysyx_22050368_regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN = ysyx_22050368_regfile_sb_pkg::XLEN,
    parameter int unsigned NREG = RFREG_NUM,
    parameter int unsigned IDXW = $clog2(NREG),
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*IDXW-1:0] rd_idx,
    output logic [NRD*XLEN-1:0] rd_dat,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_valid,
    input  logic [IDXW-1:0]     iss_rd,
    output logic                iss_ready,
    input  logic [NWR-1:0]      wb_wen,
    input  logic [NWR*IDXW-1:0] wb_idx,
    input  logic [NWR*XLEN-1:0] wb_dat,
    output logic [XLEN-1:0]     x1_r
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [NREG-1:0] busy;

    ysyx_22050368_rf_scoreboard #(
        .NREG (NREG),
        .IDXW (IDXW),
        .NWR  (NWR)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .iss_ready_o (iss_ready),
        .wb_wen_i    (wb_wen),
        .wb_idx_i    (wb_idx),
        .busy_o      (busy)
    );

    // Later loop iterations override earlier ones, so the highest port wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wb_wen[j] && (wb_idx[j*IDXW +: IDXW] != '0)) begin
                    rf_q[wb_idx[j*IDXW +: IDXW]] <= wb_dat[j*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [IDXW-1:0] idx;
        logic [XLEN-1:0] dat;
        logic            bsy;

        assign idx = rd_idx[k*IDXW +: IDXW];

        always_comb begin
            dat = (idx == '0) ? '0 : rf_q[idx];
            bsy = busy[idx] & (idx != '0);
`ifdef REGFILE_BYPASS_EN
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wb_wen[j] && (wb_idx[j*IDXW +: IDXW] == idx) && (idx != '0)) begin
                    dat = wb_dat[j*XLEN +: XLEN];
                    bsy = 1'b0;
                end
            end
`endif
        end

        assign rd_dat[k*XLEN +: XLEN] = dat;
        assign rd_busy[k]             = bsy;
    end

    always_comb begin
        x1_r = rf_q[1];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wb_wen[j] && (wb_idx[j*IDXW +: IDXW] == IDXW'(1))) begin
                x1_r = wb_dat[j*XLEN +: XLEN];
            end
        end
`endif
    end

endmodule

// File: tb/tb_ysyx_22050368_regfile_sb.sv
// Scoreboard bench: the driver pushes per-cycle expectations from an array model,
// the monitor pops and compares on the falling edge.
module tb_ysyx_22050368_regfile_sb;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   rd_idx;
    logic [127:0] rd_dat;
    logic [1:0]   rd_busy;
    logic         iss_valid;
    logic [4:0]   iss_rd;
    logic         iss_ready;
    logic [1:0]   wb_wen;
    logic [9:0]   wb_idx;
    logic [127:0] wb_dat;
    logic [63:0]  x1_r;

    always #5 clk = ~clk;

    ysyx_22050368_regfile_sb #(
        .XLEN (64),
        .NREG (32),
        .IDXW (5),
        .NRD  (2),
        .NWR  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx),
        .rd_dat    (rd_dat),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .wb_wen    (wb_wen),
        .wb_idx    (wb_idx),
        .wb_dat    (wb_dat),
        .x1_r      (x1_r)
    );

    typedef struct {
        logic [127:0] dat;
        logic [1:0]   busy;
        logic         ready;
        logic [63:0]  x1;
    } exp_t;

    exp_t exp_q[$];
    int   nchecks = 0;
    int   nerr    = 0;

    // Architectural model: register contents and outstanding claims.
    logic [63:0] m_reg  [32];
    bit          m_busy [32];
    bit          last_ready;

    function automatic logic [63:0] model_read(input logic [4:0] idx, input logic [1:0] wen,
                                               input logic [4:0] w0, input logic [4:0] w1,
                                               input logic [63:0] d0, input logic [63:0] d1,
                                               output bit bsy);
        logic [63:0] v;
        if (idx == 0) begin
            bsy = 0;
            return 64'd0;
        end
        v   = m_reg[idx];
        bsy = m_busy[idx];
`ifdef REGFILE_BYPASS_EN
        if (wen[1] && w1 == idx) begin
            v = d1; bsy = 0;
        end else if (wen[0] && w0 == idx) begin
            v = d0; bsy = 0;
        end
`endif
        return v;
    endfunction

    task automatic cyc(input logic r, input logic [4:0] r0, input logic [4:0] r1,
                       input logic iv, input logic [4:0] ird, input logic [1:0] wen,
                       input logic [4:0] w0, input logic [4:0] w1,
                       input logic [63:0] d0, input logic [63:0] d1);
        exp_t e;
        bit   b0, b1, bx;
        @(posedge clk);
        #1;
        rst       = r;
        rd_idx    = {r1, r0};
        iss_valid = iv;
        iss_rd    = ird;
        wb_wen    = wen;
        wb_idx    = {w1, w0};
        wb_dat    = {d1, d0};

        e.dat[63:0]   = model_read(r0, wen, w0, w1, d0, d1, b0);
        e.dat[127:64] = model_read(r1, wen, w0, w1, d0, d1, b1);
        e.busy        = {b1, b0};
        e.x1          = model_read(5'd1, wen, w0, w1, d0, d1, bx);
        e.ready       = (ird == 0) || !m_busy[ird] ||
                        (wen[0] && w0 == ird) || (wen[1] && w1 == ird);
        exp_q.push_back(e);
        last_ready = e.ready;

        if (!r) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = 64'd0;
                m_busy[i] = 0;
            end
        end else begin
            if (wen[0] && w0 != 0) begin m_reg[w0] = d0; m_busy[w0] = 0; end
            if (wen[1] && w1 != 0) begin m_reg[w1] = d1; m_busy[w1] = 0; end
            if (iv && e.ready && ird != 0) m_busy[ird] = 1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                nchecks++;
                if (rd_dat !== e.dat) begin
                    nerr++;
                    $display("FAIL rd_dat at %0t: got %h want %h", $time, rd_dat, e.dat);
                end
                nchecks++;
                if (rd_busy !== e.busy) begin
                    nerr++;
                    $display("FAIL rd_busy at %0t: got %b want %b", $time, rd_busy, e.busy);
                end
                nchecks++;
                if (iss_ready !== e.ready) begin
                    nerr++;
                    $display("FAIL iss_ready at %0t: got %b want %b", $time, iss_ready, e.ready);
                end
                nchecks++;
                if (x1_r !== e.x1) begin
                    nerr++;
                    $display("FAIL x1_r at %0t: got %h want %h", $time, x1_r, e.x1);
                end
            end
        end
    end

    initial begin : driver
        bit         pv;
        logic [4:0] prd;
        logic [1:0] wen;
        logic       rr;

        rst = 1'b0; rd_idx = '0; iss_valid = 1'b0; iss_rd = '0;
        wb_wen = '0; wb_idx = '0; wb_dat = '0;
        for (int i = 0; i < 32; i++) begin m_reg[i] = 64'd0; m_busy[i] = 0; end
        @(posedge clk);

        // Reset clears a previously written register.
        cyc(1, 5, 0, 0, 0, 2'b01, 5, 0, 64'hA5, 0);
        cyc(0, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        cyc(1, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        // Same-index write collision: port 1 wins.
        cyc(1, 7, 7, 0, 0, 2'b11, 7, 7, 64'h11, 64'h22);
        cyc(1, 7, 7, 0, 0, 2'b00, 0, 0, 0, 0);
        // x0 stays zero and never busy.
        cyc(1, 0, 0, 1, 0, 2'b01, 0, 0, 64'hFFFF, 0);
        cyc(1, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        // Scoreboard stall released by same-cycle write-back, then re-claimed.
        cyc(1, 3, 3, 1, 3, 2'b00, 0, 0, 0, 0);
        cyc(1, 3, 3, 1, 3, 2'b00, 0, 0, 0, 0);
        cyc(1, 3, 3, 1, 3, 2'b01, 3, 0, 64'h5, 0);
        cyc(1, 3, 3, 0, 0, 2'b00, 0, 0, 0, 0);
        // Write-to-read on the same cycle and x1 tap.
        cyc(1, 9, 9, 0, 0, 2'b10, 0, 9, 0, 64'h1234);
        cyc(1, 9, 9, 0, 0, 2'b00, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 2'b01, 1, 0, 64'hBEEF, 0);
        cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        // Reset while a claim is outstanding, then a late write-back.
        cyc(1, 4, 4, 1, 4, 2'b00, 0, 0, 0, 0);
        cyc(0, 4, 4, 0, 0, 2'b00, 0, 0, 0, 0);
        cyc(1, 4, 4, 0, 0, 2'b00, 0, 0, 0, 0);
        cyc(1, 4, 4, 0, 0, 2'b01, 4, 0, 64'h9, 0);
        cyc(1, 4, 4, 0, 0, 2'b00, 0, 0, 0, 0);

        // Random traffic on a narrow index range to force conflicts.
        pv = 0; prd = '0;
        for (int unsigned n = 0; n < 3000; n++) begin
            if (!pv) begin
                pv  = ($urandom_range(0, 1) == 1);
                prd = 5'($urandom_range(0, 7));
            end
            wen = 2'($urandom);
            rr  = ($urandom_range(0, 99) != 0);
            cyc(rr, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), pv, prd, wen,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                {$urandom, $urandom}, {$urandom, $urandom});
            if (pv && last_ready) pv = 0;
        end

        repeat (3) @(negedge clk);
        nchecks++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
